an_encoder_n13_seq: RTL and testbench



---
 rtl/an_encoder_n13_seq_if.sv | 28 ++
 rtl/an_encoder_n13_seq.sv | 135 +++++++++++++
 tb/tb_an_encoder_n13_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/an_encoder_n13_seq_if.sv
// ----------------------------------------------------------------------------
// an_encoder_n13_seq_if
// Handshake bundle for the A=13 AN-code encoder.
//   in_valid / in_msg / in_ready           : message stream into the encoder
//   out_valid / out_codeword / out_ovf /
//   out_ready                              : codeword stream to the decoder
// Modports: master = producer/consumer side (bench or neighbouring stages),
//           slave  = encoder side.
// ----------------------------------------------------------------------------
interface an_encoder_n13_seq_if;
   logic       in_valid;
   logic [2:0] in_msg;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_codeword;
   logic       out_ovf;

   modport master (
      output in_valid, in_msg, out_ready,
      input  in_ready, out_valid, out_codeword, out_ovf
   );

   modport slave (
      input  in_valid, in_msg, out_ready,
      output in_ready, out_valid, out_codeword, out_ovf
   );
endinterface

// File: rtl/an_encoder_n13_seq.sv
// ----------------------------------------------------------------------------
// an_encoder_n13_seq
// Sequential AN-code encoder, A=13, 3-bit message -> 6-bit codeword.
// The codeword 13*msg is formed by a 3-cycle shift-add multiplier (one message
// bit per cycle) and held until the downstream stage accepts it. Products that
// do not fit 6 bits (msg 5..7) are flagged on out_ovf.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus          : slave side of an_encoder_n13_seq_if (in_*/out_* streams)
//   enc_count    : codewords delivered since reset, saturates at 255
//   fault_en     : (AN_ENC_FAULT_INJ_EN only) XOR fault_mask into the codeword
//   fault_mask   : (AN_ENC_FAULT_INJ_EN only) bits to flip in the codeword
// Build option: define AN_ENC_FAULT_INJ_EN to add the fault-injection ports.
// ----------------------------------------------------------------------------
module an_encoder_n13_seq (
   input  logic                        clk,
   input  logic                        rst_n,
   an_encoder_n13_seq_if.slave         bus,
   output logic [7:0]                  enc_count
`ifdef AN_ENC_FAULT_INJ_EN
   ,
   input  logic                        fault_en,
   input  logic [5:0]                  fault_mask
`endif
);

   localparam int unsigned MSG_W = 3;
   localparam int unsigned CW_W  = 6;
   localparam int unsigned ACC_W = 7;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t             r_state;
   logic [MSG_W-1:0]   r_msg;
   logic [ACC_W-1:0]   r_acc;
   logic [1:0]         r_k;
   logic [CW_W-1:0]    r_codeword;
   logic               r_ovf;
   logic               r_out_valid;
   logic [CNT_W-1:0]   r_enc_count;
`ifdef AN_ENC_FAULT_INJ_EN
   logic [CW_W-1:0]    r_mask;
`endif

   logic [ACC_W-1:0]   w_addend;
   logic [ACC_W-1:0]   w_acc_next;
   logic [CW_W-1:0]    w_cw_next;
   logic               w_in_ready;

   // Partial product for the current message bit; 13<<2 = 52 fits in 7 bits.
   always_comb begin
      w_addend = '0;
      if (r_msg[r_k]) begin
         w_addend = ACC_W'(ACC_W'(13) << r_k);
      end
      w_acc_next = r_acc + w_addend;
`ifdef AN_ENC_FAULT_INJ_EN
      w_cw_next  = w_acc_next[CW_W-1:0] ^ r_mask;
`else
      w_cw_next  = w_acc_next[CW_W-1:0];
`endif
   end

   // Ready depends only on registered state, never on out_ready.
   assign w_in_ready = (r_state == S_IDLE);

   // Control FSM, multiplier datapath and delivery counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_msg       <= '0;
         r_acc       <= '0;
         r_k         <= '0;
         r_codeword  <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_enc_count <= '0;
`ifdef AN_ENC_FAULT_INJ_EN
         r_mask      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_msg   <= bus.in_msg;
                  r_acc   <= '0;
                  r_k     <= '0;
`ifdef AN_ENC_FAULT_INJ_EN
                  r_mask  <= fault_en ? fault_mask : '0;
`endif
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               r_acc <= w_acc_next;
               r_k   <= r_k + 2'd1;
               if (r_k == 2'd2) begin
                  // Overflow flag always reflects the unmasked product.
                  r_codeword  <= w_cw_next;
                  r_ovf       <= w_acc_next[ACC_W-1];
                  r_out_valid <= 1'b1;
                  r_k         <= '0;
                  r_state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
                  if (r_enc_count != CNT_W'(255)) begin
                     r_enc_count <= r_enc_count + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_codeword = r_codeword;
   assign bus.out_ovf      = r_ovf;
   assign enc_count        = r_enc_count;

endmodule

// File: tb/tb_an_encoder_n13_seq.sv
// ----------------------------------------------------------------------------
// tb_an_encoder_n13_seq
// Directed bench for an_encoder_n13_seq: literal expectations per transaction
// plus a cycle-level reference model (pending word, due cycle, delivery count)
// compared against the DUT on every falling edge.
// ----------------------------------------------------------------------------
module tb_an_encoder_n13_seq;

   logic       clk;
   logic       rst_n;
   logic [7:0] enc_count;
`ifdef AN_ENC_FAULT_INJ_EN
   logic       fault_en;
   logic [5:0] fault_mask;
`endif

   an_encoder_n13_seq_if bus ();

   an_encoder_n13_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .enc_count  (enc_count)
`ifdef AN_ENC_FAULT_INJ_EN
      ,
      .fault_en   (fault_en),
      .fault_mask (fault_mask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: one word in flight, valid from due cycle until taken.
   bit         m_busy  = 1'b0;
   int         m_due   = 0;
   logic [5:0] m_cw    = '0;
   logic       m_ovf   = 1'b0;
   int         m_count = 0;

   always @(negedge clk) begin
      int  prod;
      bit  exp_valid;
      if (cyc >= 1) begin
         exp_valid = m_busy && (cyc >= m_due);
         chk("m_in_ready",  32'(bus.in_ready),  32'(!m_busy));
         chk("m_out_valid", 32'(bus.out_valid), 32'(exp_valid));
         chk("m_enc_count", 32'(enc_count),     32'(m_count));
         if (exp_valid) begin
            chk("m_codeword", 32'(bus.out_codeword), 32'(m_cw));
            chk("m_ovf",      32'(bus.out_ovf),      32'(m_ovf));
         end
         // Advance the model to what the coming rising edge will do.
         if (!rst_n) begin
            m_busy  = 1'b0;
            m_count = 0;
         end else if (!m_busy && bus.in_valid) begin
            prod   = 13 * int'(bus.in_msg);
            m_cw   = 6'(prod % 64);
            m_ovf  = (prod >= 64);
`ifdef AN_ENC_FAULT_INJ_EN
            if (fault_en) m_cw = m_cw ^ fault_mask;
`endif
            m_busy = 1'b1;
            m_due  = cyc + 4;
         end else if (exp_valid && bus.out_ready) begin
            m_busy = 1'b0;
            if (m_count < 255) m_count++;
         end
      end
   end

   // Send one message, check latency and result, hold out_ready low for
   // 'hold' extra cycles, then complete the output handshake.
   task automatic encode(input logic [2:0] msg, input logic [5:0] e_cw,
                         input logic e_ovf, input int hold);
      int lat;
      bit ok;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_msg   = msg;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         chk("accept_timeout", 32'(0), 32'(1));
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_msg   = 3'($urandom_range(0, 7));
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin ok = 1'b1; break; end
         lat++;
      end
      if (!ok) begin
         chk("out_valid_timeout", 32'(0), 32'(1));
         return;
      end
      chk("latency",  32'(lat),              32'(3));
      chk("codeword", 32'(bus.out_codeword), 32'(e_cw));
      chk("ovf",      32'(bus.out_ovf),      32'(e_ovf));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_codeword", 32'(bus.out_codeword), 32'(e_cw));
         chk("bp_in_ready", 32'(bus.in_ready),     32'(0));
         chk("bp_valid",    32'(bus.out_valid),    32'(1));
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   logic [5:0] cw_tbl  [8] = '{6'd0, 6'd13, 6'd26, 6'd39, 6'd52, 6'd1, 6'd14, 6'd27};
   logic       ovf_tbl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      rst_n            = 1'b0;
      bus.in_valid     = 1'b0;
      bus.in_msg       = '0;
      bus.out_ready    = 1'b0;
`ifdef AN_ENC_FAULT_INJ_EN
      fault_en         = 1'b0;
      fault_mask       = '0;
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),     32'(1));
      chk("rst_out_valid", 32'(bus.out_valid),    32'(0));
      chk("rst_codeword",  32'(bus.out_codeword), 32'(0));
      chk("rst_ovf",       32'(bus.out_ovf),      32'(0));
      chk("rst_count",     32'(enc_count),        32'(0));

      // msg 3 -> 39, count 0 -> 1
      encode(3'd3, 6'h27, 1'b0, 0);
      @(negedge clk);
      chk("count_after_first", 32'(enc_count), 32'(1));

      // Full sweep 0..7
      for (int m = 0; m < 8; m++) encode(3'(m), cw_tbl[m], ovf_tbl[m], 0);
      @(negedge clk);
      chk("count_after_sweep", 32'(enc_count), 32'(9));

      // Backpressure: msg 4 held for 6 cycles
      encode(3'd4, 6'd52, 1'b0, 6);
      @(negedge clk);
      chk("count_after_bp", 32'(enc_count), 32'(10));

      // Reset one cycle after acceptance
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_msg   = 3'd5;
      @(negedge clk);
      chk("rst_mid_accept", 32'(bus.in_ready), 32'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 32'(bus.out_valid),    32'(0));
      chk("midrst_codeword",  32'(bus.out_codeword), 32'(0));
      chk("midrst_in_ready",  32'(bus.in_ready),     32'(1));
      chk("midrst_count",     32'(enc_count),        32'(0));
      encode(3'd1, 6'd13, 1'b0, 0);

`ifdef AN_ENC_FAULT_INJ_EN
      fault_en   = 1'b1;
      fault_mask = 6'h01;
      encode(3'd2, 6'd27, 1'b0, 0);
      fault_en   = 1'b0;
      fault_mask = '0;
`endif

      // Saturation: 260 more encodes
      for (int n = 0; n < 260; n++) encode(3'(n % 8), cw_tbl[n % 8], ovf_tbl[n % 8], 0);
      @(negedge clk);
      chk("count_saturated", 32'(enc_count), 32'(255));
      encode(3'd2, 6'd26, 1'b0, 0);
      @(negedge clk);
      chk("count_stays_255", 32'(enc_count), 32'(255));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
